timing_decode_unit: RTL and testbench

- Produces the two inputs the control unit consumes: the one-hot T-state ring `timer[7:0]` and the one-hot instruction decode `IR_dicode[15:0]`.
- Consumes the control unit's `reset_timer`, `load_IR` and `finish_signal` outputs.
- Holds the instruction register, loaded from the shared data bus.
- Adds run/halt/single-step sequencing so the machine can stop on the finish instruction and be restarted or stepped.

---
 rtl/timing_decode_unit.sv | 98 +++++++++
 tb/tb_timing_decode_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/timing_decode_unit.sv
// T-state ring, instruction register and opcode decode for the control unit,
// with run/halt/single-step sequencing around the finish instruction.
module timing_decode_unit #(
  parameter int DATA_W = 8,
  parameter int OPC_W  = 4,
  parameter int T_W    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       bus_in,
  input  logic                    load_IR,
  input  logic                    reset_timer,
  input  logic                    finish_signal,
  input  logic                    run_req,
  input  logic                    step_mode,
  input  logic                    step_pulse,
  output logic [T_W-1:0]          timer,
  output logic [(1<<OPC_W)-1:0]   IR_dicode,
  output logic [DATA_W-OPC_W-1:0] ir_operand,
  output logic [DATA_W-1:0]       ir_out,
  output logic                    halted
);

  localparam int DEC_W = 1 << OPC_W;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] ir;
  logic              ir_valid;
  logic              adv;

  // Advance enable: free-run, or gated by the step pulse; never while halted.
  always_comb begin
    adv = 1'b0;
    if (state == RUN) begin
      adv = step_mode ? step_pulse : 1'b1;
    end
  end

  // Sequencer: timer ring, IR capture and RUN/HALT transitions.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      timer    <= T_W'(1);
      ir       <= '0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (adv) begin
            if (finish_signal) begin
              state  <= HALT;
              timer  <= '0;
              halted <= 1'b1;
            end else if (reset_timer) begin
              timer <= T_W'(1);
            end else begin
              timer <= {timer[T_W-2:0], timer[T_W-1]};
            end
            if (load_IR) begin
              ir       <= bus_in;
              ir_valid <= 1'b1;
            end
          end
        end
        HALT: begin
          if (run_req) begin
            state  <= RUN;
            timer  <= T_W'(1);
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          timer  <= T_W'(1);
          halted <= 1'b0;
        end
      endcase
    end
  end

  // One-hot opcode decode from the IR's upper field; blank until first load.
  always_comb begin
    IR_dicode = '0;
    if (ir_valid) begin
      IR_dicode = DEC_W'(1) << ir[DATA_W-1 -: OPC_W];
    end
  end

  assign ir_operand = ir[DATA_W-OPC_W-1:0];
  assign ir_out     = ir;

endmodule

// File: tb/tb_timing_decode_unit.sv
// Directed bench for timing_decode_unit with hand-computed expected values.
module tb_timing_decode_unit;

  logic        clk;
  logic        reset;
  logic [7:0]  bus_in;
  logic        load_IR;
  logic        reset_timer;
  logic        finish_signal;
  logic        run_req;
  logic        step_mode;
  logic        step_pulse;
  logic [7:0]  timer;
  logic [15:0] IR_dicode;
  logic [3:0]  ir_operand;
  logic [7:0]  ir_out;
  logic        halted;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [7:0]  exp_timer;

  timing_decode_unit #(.DATA_W(8), .OPC_W(4), .T_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus_in        (bus_in),
    .load_IR       (load_IR),
    .reset_timer   (reset_timer),
    .finish_signal (finish_signal),
    .run_req       (run_req),
    .step_mode     (step_mode),
    .step_pulse    (step_pulse),
    .timer         (timer),
    .IR_dicode     (IR_dicode),
    .ir_operand    (ir_operand),
    .ir_out        (ir_out),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; bus_in = '0; load_IR = 0; reset_timer = 0; finish_signal = 0;
    run_req = 0; step_mode = 0; step_pulse = 0;
    tick();
    reset = 1'b0;
    check("rst_timer", timer, 8'h01);
    check("rst_dicode", IR_dicode, 16'h0000);
    check("rst_halted", halted, 1'b0);
    check("rst_ir", ir_out, 8'h00);
    check("rst_operand", ir_operand, 4'h0);

    // Free-run ring walk with wrap from T7 to T0.
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("ring", timer, 32'(8'h01 << (i % 8)));
      check("ring_dicode", IR_dicode, 16'h0000);
    end

    // Load 3A at T1, then reset_timer at T5.
    tick();
    check("t1", timer, 8'h02);
    bus_in = 8'h3A; load_IR = 1;
    tick();
    load_IR = 0;
    check("ld3a_ir", ir_out, 8'h3A);
    check("ld3a_dicode", IR_dicode, 16'h0008);
    check("ld3a_operand", ir_operand, 4'hA);
    check("ld3a_timer", timer, 8'h04);
    tick(); tick(); tick();
    check("t5", timer, 8'h20);
    reset_timer = 1;
    tick();
    reset_timer = 0;
    check("rt_t0", timer, 8'h01);

    // Load F0, finish + reset_timer at T3 -> HALT.
    bus_in = 8'hF0; load_IR = 1;
    tick();
    load_IR = 0;
    check("ldf0_dicode", IR_dicode, 16'h8000);
    tick(); tick();
    check("t3", timer, 8'h08);
    finish_signal = 1; reset_timer = 1;
    tick();
    finish_signal = 0; reset_timer = 0;
    check("halt_timer", timer, 8'h00);
    check("halt_flag", halted, 1'b1);
    check("halt_dicode", IR_dicode, 16'h8000);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin bus_in = 8'h11; load_IR = 1; step_pulse = 1; reset_timer = 1; end
      tick();
      load_IR = 0; step_pulse = 0; reset_timer = 0;
      check("halt_hold_timer", timer, 8'h00);
      check("halt_hold_ir", ir_out, 8'hF0);
      check("halt_hold_flag", halted, 1'b1);
    end
    run_req = 1;
    tick();
    run_req = 0;
    check("run_timer", timer, 8'h01);
    check("run_halted", halted, 1'b0);
    check("run_ir", ir_out, 8'hF0);
    run_req = 1;
    tick();
    run_req = 0;
    check("runreq_in_run", timer, 8'h02);

    // Single-step: pulse every third cycle.
    step_mode = 1;
    exp_timer = 8'h02;
    for (int c = 0; c < 9; c++) begin
      step_pulse = (c % 3 == 2);
      if (step_pulse) exp_timer = {exp_timer[6:0], exp_timer[7]};
      tick();
      step_pulse = 0;
      check("step", timer, 32'(exp_timer));
    end
    check("step_end", timer, 8'h10);
    reset_timer = 1;
    tick();
    check("step_rt_hold1", timer, 8'h10);
    tick();
    check("step_rt_hold2", timer, 8'h10);
    step_pulse = 1;
    tick();
    step_pulse = 0; reset_timer = 0;
    check("step_rt_apply", timer, 8'h01);
    step_mode = 0;
    tick();
    check("freerun_again", timer, 8'h02);

    // Reset at T4 with a concurrent load.
    tick(); tick(); tick();
    check("t4", timer, 8'h10);
    reset = 1; load_IR = 1; bus_in = 8'h55;
    tick();
    reset = 0; load_IR = 0;
    check("midrst_timer", timer, 8'h01);
    check("midrst_ir", ir_out, 8'h00);
    check("midrst_dicode", IR_dicode, 16'h0000);
    check("midrst_halted", halted, 1'b0);

    // Reset while halted.
    finish_signal = 1;
    tick();
    finish_signal = 0;
    check("halt2", halted, 1'b1);
    check("halt2_timer", timer, 8'h00);
    reset = 1;
    tick();
    reset = 0;
    check("halt_rst_timer", timer, 8'h01);
    check("halt_rst_halted", halted, 1'b0);
    tick();
    check("halt_rst_run", timer, 8'h02);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
